axi_sram_responder: RTL and testbench
=====================================

Name: axi_sram_responder

Overview:
- AXI3-style slave (responder) that terminates the CPU top's AXI master port in simulation and FPGA bring-up, backed by an internal word-addressed RAM.
- Independent read and write channel FSMs. INCR/FIXED bursts up to 256 beats. OKAY/SLVERR/DECERR responses.
- Drop-in memory model opposite the CPU's transfer bridge. The ID, size and length fields match the CPU master port.

Parameters:
- ADDR_BITS, 16, word-index width; RAM holds 2^ADDR_BITS 32-bit words.
- DELAY, 3, AR-to-first-R cycles; used only when AXI_RESP_DELAY_EN is defined.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read address.
- arlock/arcache/arprot  in  2/4/3  accepted, ignored.
- arvalid  in  1; arready  out  1.
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1; rready  in  1.
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write address.
- awlock/awcache/awprot  in  2/4/3  ignored.
- awvalid  in  1; awready  out  1.
- wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1; wready  out  1.
- bid/bresp/bvalid  out  4/2/1; bready  in  1.

Behaviour:
- Reset (areset high, asynchronous): all outputs 0, both FSMs to IDLE; RAM contents not reset. The first arready/awready is 1 in the cycle after areset falls.
- Address decode: word index = addr[ADDR_BITS+1:2]. addr[31:ADDR_BITS+2] != 0 → DECERR (2'b11).
  - Else size > 2 or burst not in {FIXED=00, INCR=01} → SLVERR (2'b10).
  - Else OKAY (00).
  - The error code is latched per burst and applied to every beat; errored beats return rdata = 0 and write nothing.
- Beat address: INCR adds (1<<size) to the latched byte address per beat; FIXED holds it. Each beat returns or writes the full word at the current word index. Wrap at the 2^ADDR_BITS boundary is silent (index truncates).
- Read FSM R_IDLE → R_WAIT → R_DATA:
  - R_IDLE: arready = 1. On arvalid & arready, latch id/addr/len/size/burst/resp. Go to R_WAIT if the delay feature is enabled, else R_DATA, and load beat 0 (rvalid = 1 in the next cycle).
  - R_DATA: rvalid = 1, rid = latched id, rlast = (beat count == len). On rvalid & rready:
    - If not last, the next beat is loaded in the same edge. Full throughput is one beat per cycle.
    - If last, go to R_IDLE with rvalid = 0 and rlast = 0 next cycle.
  - rdata/rresp/rlast are held stable while rvalid & !rready.
- Write FSM W_IDLE → W_DATA → W_RESP:
  - W_IDLE: awready = 1. On handshake, latch fields and go to W_DATA.
  - W_DATA: wready = 1. wready is never asserted before its AW is accepted. Each wvalid & wready writes RAM bytes per wstrb (when resp is OKAY) and advances the address.
  - Burst end is governed by the beat count, not wlast. wlast low on the final beat, or high early, sets a sticky SLVERR for that burst's bresp. wid is ignored.
  - After the final beat, go to W_RESP: bvalid = 1, bid = latched awid, bresp = latched resp. On bready, return to W_IDLE.
- Concurrency: reads and writes proceed in parallel. If a read beat loads the same word being written in that cycle, it returns the old data.
- Outstanding transactions: one per channel; no reordering. rid/bid always echo the accepting ID.
- Reset mid-burst: the burst is abandoned. No partial B or R is emitted after reset release.

Optional Feature:
- AXI_RESP_DELAY_EN defined: after AR accept, the FSM sits in R_WAIT for DELAY cycles (arready = 0, rvalid = 0) before R_DATA. Likewise, bvalid rises DELAY cycles after the final W beat.
- Not defined: R_WAIT is unused; the first R beat and bvalid appear the cycle after the triggering handshake.

Test Plan:
- Single write then read: AW addr 0x100, len 0, size 2, wdata 0xDEADBEEF, wstrb 0xF → bresp 0, bid = awid. AR 0x100 → rdata 0xDEADBEEF, rlast 1, rresp 0, rid = arid.
- Byte strobes: write 0x11223344 (wstrb F), then 0xAABBCCDD with wstrb 0x5 at the same address → read returns 0x11BB33DD.
- INCR read burst: pre-load words 0x200..0x20C with 1..4; AR len 3, INCR; rready toggling 1,0,1,1,0,1 → beats 1,2,3,4 in order, rlast only on beat 4, data stable across stalls.
- Errors:
  - AR araddr 0x8000_0000 (ADDR_BITS 16) → rresp 2'b11, rdata 0.
  - AW arsize 3 → bresp 2'b10, RAM unchanged.
  - AW len 1 with wlast on beat 0 → bresp 2'b10.
- Concurrency: a 4-beat read and a 4-beat write to disjoint addresses issued in the same cycle → both complete with OKAY, with no extra stall cycles on either channel.
- Reset mid-burst: areset pulsed during beat 2 of a 4-beat read → rvalid 0 immediately; arready 1 one cycle after release; the next single read returns correct data.

Source files
------------

// File: rtl/axi_sram_responder.sv
// AXI3 slave backed by a word-addressed RAM, with independent read/write FSMs.
// Define AXI_RESP_DELAY_EN to insert DELAY cycles before the first R beat and B.
module axi_sram_responder #(
    parameter int ADDR_BITS = 16,
    parameter int DELAY     = 3
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    logic [31:0] mem [0:(1<<ADDR_BITS)-1];

    function automatic logic [1:0] decode(input logic [31:0] a,
                                          input logic [2:0]  s,
                                          input logic [1:0]  b);
        if (a[31:ADDR_BITS+2] != '0) return DECERR;
        if (s > 3'd2 || b[1]) return SLVERR;
        return OKAY;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a,
                                              input logic [2:0]  s,
                                              input logic [1:0]  b);
        return (b == 2'b01) ? a + (32'd1 << s) : a;
    endfunction

    // Errored beats never touch the array and return zero.
    function automatic logic [31:0] rd_word(input logic [31:0] a,
                                            input logic [1:0]  e);
        return (e == OKAY) ? mem[a[ADDR_BITS+1:2]] : 32'd0;
    endfunction

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

    r_state_t    r_state;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_beat;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [1:0]  r_err;
    logic [31:0] r_next;
    logic [1:0]  ar_err;
    logic [7:0]  r_dcnt;

    assign r_next = next_addr(r_addr, r_size, r_burst);
    assign ar_err = decode(araddr, arsize, arburst);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
            rresp   <= '0;
            rid     <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= '0;
            r_dcnt  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        arready <= 1'b0;
                        rid     <= arid;
                        r_addr  <= araddr;
                        r_len   <= arlen;
                        r_size  <= arsize;
                        r_burst <= arburst;
                        r_err   <= ar_err;
                        r_beat  <= '0;
                        r_dcnt  <= '0;
`ifdef AXI_RESP_DELAY_EN
                        r_state <= R_WAIT;
`else
                        rvalid  <= 1'b1;
                        rdata   <= rd_word(araddr, ar_err);
                        rresp   <= ar_err;
                        rlast   <= (arlen == 8'd0);
                        r_state <= R_DATA;
`endif
                    end
                end
                R_WAIT: begin
`ifdef AXI_RESP_DELAY_EN
                    if (r_dcnt == 8'(DELAY - 1)) begin
                        rvalid  <= 1'b1;
                        rdata   <= rd_word(r_addr, r_err);
                        rresp   <= r_err;
                        rlast   <= (r_len == 8'd0);
                        r_state <= R_DATA;
                    end else begin
                        r_dcnt <= r_dcnt + 8'd1;
                    end
`else
                    r_state <= R_IDLE;
`endif
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= r_next;
                            r_beat <= r_beat + 8'd1;
                            rdata  <= rd_word(r_next, r_err);
                            rlast  <= (r_beat + 8'd1 == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    w_state_t    w_state;
    logic [31:0] w_addr;
    logic [7:0]  w_len;
    logic [7:0]  w_beat;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic [1:0]  w_err;
    logic        w_sticky;
    logic [7:0]  w_dcnt;
    logic        w_fire;
    logic        w_final;
    logic        w_last_bad;
    logic [1:0]  b_code;

    assign w_fire     = (w_state == W_DATA) && wvalid && wready;
    assign w_final    = (w_beat == w_len);
    assign w_last_bad = (wlast != w_final);
    assign b_code     = (w_err != OKAY) ? w_err :
                        (w_sticky || w_last_bad) ? SLVERR : OKAY;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state  <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= '0;
            bid      <= '0;
            w_addr   <= '0;
            w_len    <= '0;
            w_beat   <= '0;
            w_size   <= '0;
            w_burst  <= '0;
            w_err    <= '0;
            w_sticky <= 1'b0;
            w_dcnt   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        bid      <= awid;
                        w_addr   <= awaddr;
                        w_len    <= awlen;
                        w_size   <= awsize;
                        w_burst  <= awburst;
                        w_err    <= decode(awaddr, awsize, awburst);
                        w_sticky <= 1'b0;
                        w_beat   <= '0;
                        w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (w_last_bad) w_sticky <= 1'b1;
                        if (w_final) begin
                            wready <= 1'b0;
                            bresp  <= b_code;
                            w_dcnt <= '0;
`ifdef AXI_RESP_DELAY_EN
                            w_state <= W_WAIT;
`else
                            bvalid  <= 1'b1;
                            w_state <= W_RESP;
`endif
                        end else begin
                            w_addr <= next_addr(w_addr, w_size, w_burst);
                            w_beat <= w_beat + 8'd1;
                        end
                    end
                end
                W_WAIT: begin
                    // One cycle is already spent by the final-beat edge.
                    if (w_dcnt >= 8'(DELAY - 1)) begin
                        bvalid  <= 1'b1;
                        w_state <= W_RESP;
                    end else begin
                        w_dcnt <= w_dcnt + 8'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (w_fire && w_err == OKAY) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[w_addr[ADDR_BITS+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    logic unused_sigs;
    assign unused_sigs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

endmodule

// File: tb/tb_axi_sram_responder.sv
// Scoreboard bench for axi_sram_responder: tasks queue expected R/B beats,
// a negedge monitor pops and compares them.
module tb_axi_sram_responder;
    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    always #5 aclk = ~aclk;

    axi_sram_responder dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(2'b00), .arcache(4'h0), .arprot(3'h0),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(2'b00), .awcache(4'h0), .awprot(3'h0),
        .awvalid(awvalid), .awready(awready),
        .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    localparam logic [1:0] OK = 2'b00, SE = 2'b10, DE = 2'b11;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];
    bit    rpat[$];
    logic [31:0] wbuf [0:7];
    logic [31:0] rbuf [0:7];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int r_first = -1, r_lastc = -1, w_first = -1, w_lastc = -1, r_hs = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    initial forever begin
        @(posedge aclk);
        #1;
        if (rvalid && rpat.size() > 0) rready = rpat.pop_front();
        else rready = 1'b1;
    end

    // Monitor: scoreboard compare plus hold-stability check on stalled R beats.
    initial begin
        logic stall_q;
        logic [31:0] s_data;
        logic s_last;
        rexp_t e;
        bexp_t b;
        stall_q = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    chk("r_hold_data", rdata, s_data);
                    chk("r_hold_last", rlast, s_last);
                end
                stall_q = rvalid && !rready;
                s_data = rdata;
                s_last = rlast;
                if (rvalid && rready) begin
                    if (r_first < 0) r_first = cyc;
                    r_lastc = cyc;
                    r_hs++;
                    if (rq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL r_extra: got unexpected beat data %0h", rdata);
                    end else begin
                        e = rq.pop_front();
                        chk("rid", rid, e.id);
                        chk("rdata", rdata, e.data);
                        chk("rresp", rresp, e.resp);
                        chk("rlast", rlast, e.last);
                    end
                end
                if (wvalid && wready) begin
                    if (w_first < 0) w_first = cyc;
                    w_lastc = cyc;
                end
                if (bvalid && bready) begin
                    if (bq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL b_extra: got unexpected B id %0h", bid);
                    end else begin
                        b = bq.pop_front();
                        chk("bid", bid, b.id);
                        chk("bresp", bresp, b.resp);
                    end
                end
            end
        end
    end

    task automatic issue_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bu, input logic [1:0] er);
        int n;
        for (int i = 0; i <= int'(len); i++)
            rq.push_back('{id, (er == OK) ? rbuf[i] : 32'd0, er, i == int'(len)});
        arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!arready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100) timeout("ar_handshake");
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu, input logic [1:0] er);
        int n;
        issue_ar(id, a, len, sz, bu, er);
        n = 0;
        while (rq.size() != 0 && n < 300) begin
            @(posedge aclk);
            n++;
        end
        if (n >= 300) begin
            timeout("r_drain");
            rq.delete();
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bu, input logic [3:0] st,
                            input bit bad_last, input logic [1:0] er);
        int n;
        bq.push_back('{id, er});
        awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!awready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100) timeout("aw_handshake");
        @(posedge aclk);
        #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1;
            wdata = wbuf[i];
            wstrb = st;
            wlast = bad_last ? (i == 0) : (i == int'(len));
            n = 0;
            @(negedge aclk);
            while (!wready && n < 100) begin
                @(negedge aclk);
                n++;
            end
            if (n >= 100) timeout("w_handshake");
            @(posedge aclk);
            #1;
        end
        wvalid = 1'b0;
        wlast = 1'b0;
        n = 0;
        while (bq.size() != 0 && n < 100) begin
            @(posedge aclk);
            n++;
        end
        if (n >= 100) begin
            timeout("b_drain");
            bq.delete();
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int n;
        areset = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b1; bready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        areset = 1'b0;
        @(negedge aclk);
        chk("arready_pre", arready, 0);
        @(posedge aclk);
        #1;
        chk("arready_post", arready, 1);
        chk("awready_post", awready, 1);

        wbuf[0] = 32'hDEADBEEF;
        do_write(4'h3, 32'h100, 0, 2, 2'b01, 4'hF, 0, OK);
        rbuf[0] = 32'hDEADBEEF;
        do_read(4'h5, 32'h100, 0, 2, 2'b01, OK);

        wbuf[0] = 32'h11223344;
        do_write(4'h1, 32'h108, 0, 2, 2'b01, 4'hF, 0, OK);
        wbuf[0] = 32'hAABBCCDD;
        do_write(4'h2, 32'h108, 0, 2, 2'b01, 4'h5, 0, OK);
        rbuf[0] = 32'h11BB33DD;
        do_read(4'h6, 32'h108, 0, 2, 2'b01, OK);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        do_write(4'h6, 32'h200, 3, 2, 2'b01, 4'hF, 0, OK);
        for (int i = 0; i < 4; i++) rbuf[i] = 32'(i + 1);
        rpat.push_back(1); rpat.push_back(0); rpat.push_back(1);
        rpat.push_back(1); rpat.push_back(0); rpat.push_back(1);
        do_read(4'h7, 32'h200, 3, 2, 2'b01, OK);

        for (int i = 0; i < 3; i++) rbuf[i] = 32'd2;
        do_read(4'h9, 32'h204, 2, 2, 2'b00, OK);

        do_read(4'hC, 32'h8000_0000, 0, 2, 2'b01, DE);
        do_read(4'hD, 32'h100, 1, 2, 2'b10, SE);

        wbuf[0] = 32'h12345678;
        do_write(4'hE, 32'h100, 0, 3, 2'b01, 4'hF, 0, SE);
        rbuf[0] = 32'hDEADBEEF;
        do_read(4'h1, 32'h100, 0, 2, 2'b01, OK);

        wbuf[0] = 32'h0; wbuf[1] = 32'h0;
        do_write(4'hF, 32'h400, 1, 2, 2'b01, 4'hF, 1, SE);

        wbuf[0] = 32'hA5A50001; wbuf[1] = 32'hA5A50002;
        do_write(4'h1, 32'h3FFFC, 1, 2, 2'b01, 4'hF, 0, OK);
        rbuf[0] = 32'hA5A50002;
        do_read(4'h2, 32'h0, 0, 2, 2'b01, OK);
        rbuf[0] = 32'hA5A50001;
        do_read(4'h3, 32'h3FFFC, 0, 2, 2'b01, OK);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 10);
        for (int i = 0; i < 4; i++) rbuf[i] = 32'(i + 1);
        r_first = -1; w_first = -1;
        fork
            do_write(4'h4, 32'h300, 3, 2, 2'b01, 4'hF, 0, OK);
            do_read(4'h8, 32'h200, 3, 2, 2'b01, OK);
        join
        chk("r_span", 64'(r_lastc - r_first), 64'd3);
        chk("w_span", 64'(w_lastc - w_first), 64'd3);
        for (int i = 0; i < 4; i++) rbuf[i] = 32'(i + 10);
        do_read(4'h5, 32'h300, 3, 2, 2'b01, OK);

        for (int i = 0; i < 4; i++) rbuf[i] = 32'(i + 1);
        r_hs = 0;
        issue_ar(4'hA, 32'h200, 3, 2, 2'b01, OK);
        n = 0;
        while (r_hs < 1 && n < 50) begin
            @(posedge aclk);
            n++;
        end
        if (n >= 50) timeout("mid_burst");
        #1;
        chk("pre_rst_rvalid", rvalid, 1);
        areset = 1'b1;
        #1;
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_arready", arready, 0);
        rq.delete();
        @(posedge aclk);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("rel_arready", arready, 0);
        chk("rel_rvalid", rvalid, 0);
        @(posedge aclk);
        #1;
        chk("rel_arready_1", arready, 1);
        chk("rel_rvalid_1", rvalid, 0);
        rbuf[0] = 32'd3;
        do_read(4'hB, 32'h208, 0, 2, 2'b01, OK);

        repeat (3) @(posedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
